// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_collector
// Function : Captures {cs, alu} on each rising done strobe into a small FIFO,
//            keeps a running result sum and a sticky drop flag.
// Revision : 1.0
// ============================================================================
module alu_result_collector #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          done_in,
    input  logic [2:0]    cs_in,
    input  logic [15:0]   alu_in,
    input  logic          flush,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [15:0]   res_data,
    output logic [2:0]    res_tag,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [15:0]   sum
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
    localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

    logic          done_q;
    logic [18:0]   mem_q   [DEPTH];
    logic [18:0]   mem_d   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   sum_q, sum_d;

    logic          w_cap;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic [18:0]   w_head;

    assign w_cap  = done_in & ~done_q;
    assign w_full = (count_q == C_FULL);
    assign w_pop  = res_valid & res_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push = w_cap & ~flush & (~w_full | w_pop);
    assign w_drop = w_cap & ~flush & w_full & ~w_pop;
    assign w_head = mem_q[rd_ptr_q];

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sum_d      = sum_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            sum_d      = '0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = {cs_in, alu_in};
                wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
                sum_d           = sum_q + alu_in;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
            if (w_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // done_q resets high so a strobe held through reset release is ignored.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            done_q     <= 1'b1;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            done_q     <= done_in;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sum_q      <= sum_d;
        end
    end

    assign res_valid = (count_q != '0);
    assign res_data  = res_valid ? w_head[15:0]  : 16'h0000;
    assign res_tag   = res_valid ? w_head[18:16] : 3'd0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign sum       = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_collector
// Function : Directed self-checking bench for alu_result_collector (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_alu_result_collector;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          done_in;
    logic [2:0]    cs_in;
    logic [15:0]   alu_in;
    logic          flush;
    logic          res_ready;
    logic          res_valid;
    logic [15:0]   res_data;
    logic [2:0]    res_tag;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   sum;

    int tests = 0;
    int fails = 0;

    alu_result_collector #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .done_in   (done_in),
        .cs_in     (cs_in),
        .alu_in    (alu_in),
        .flush     (flush),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .count     (count),
        .overflow  (overflow),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // One-cycle done pulse followed by one idle cycle.
    task automatic capture(input logic [15:0] val, input logic [2:0] tag);
        done_in = 1'b1;
        alu_in  = val;
        cs_in   = tag;
        tick();
        done_in = 1'b0;
        tick();
    endtask

    initial begin
        clear_n   = 1'b0;
        done_in   = 1'b0;
        cs_in     = 3'd0;
        alu_in    = 16'h0000;
        flush     = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'h0);
        chk("rst_tag", 32'(res_tag), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);
        clear_n = 1'b1;
        tick();

        // Single pulse
        done_in = 1'b1; alu_in = 16'h1234; cs_in = 3'd5;
        tick();
        done_in = 1'b0;
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_data", 32'(res_data), 32'h1234);
        chk("t1_tag", 32'(res_tag), 32'd5);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_sum", 32'(sum), 32'h1234);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_pop_valid", 32'(res_valid), 32'd0);

        // Level held 6 cycles: one capture of the first value
        done_in = 1'b1; alu_in = 16'hA000; cs_in = 3'd3;
        tick();
        for (int i = 1; i < 6; i++) begin
            alu_in = 16'hA000 + 16'(i);
            tick();
        end
        done_in = 1'b0;
        tick();
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_data", 32'(res_data), 32'hA000);
        chk("t2_sum", 32'(sum), 32'hB234);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Overflow: five captures into four entries
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_sum", 32'(sum), 32'h0);
        for (int i = 1; i <= 5; i++) capture(16'(i), 3'd1);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_sum", 32'(sum), 32'h000A);
        res_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_pop_data", 32'(res_data), 32'(i));
            tick();
        end
        res_ready = 1'b0;
        chk("t3_empty", 32'(res_valid), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with capture coincident with pop
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        capture(16'h0010, 3'd2);
        capture(16'h0020, 3'd2);
        capture(16'h0030, 3'd2);
        capture(16'h0040, 3'd2);
        chk("t4_full", 32'(count), 32'd4);
        done_in = 1'b1; alu_in = 16'h00FF; cs_in = 3'd6; res_ready = 1'b1;
        tick();
        done_in = 1'b0; res_ready = 1'b0;
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_sum", 32'(sum), 32'h019F);
        chk("t4_head", 32'(res_data), 32'h0020);
        res_ready = 1'b1;
        tick(); tick(); tick();
        chk("t4_last_data", 32'(res_data), 32'h00FF);
        chk("t4_last_tag", 32'(res_tag), 32'd6);
        tick();
        res_ready = 1'b0;
        chk("t4_empty", 32'(res_valid), 32'd0);

        // Sum wrap, then flush coincident with a capture
        flush = 1'b1;
        tick();
        flush = 1'b0;
        capture(16'hFFFF, 3'd0);
        capture(16'h0003, 3'd0);
        chk("t5_sum_wrap", 32'(sum), 32'h0002);
        chk("t5_count", 32'(count), 32'd2);
        done_in = 1'b1; alu_in = 16'h0007; flush = 1'b1;
        tick();
        done_in = 1'b0; flush = 1'b0;
        chk("t5_fl_count", 32'(count), 32'd0);
        chk("t5_fl_sum", 32'(sum), 32'h0);
        chk("t5_fl_ovf", 32'(overflow), 32'd0);
        tick();
        chk("t5_no_entry", 32'(res_valid), 32'd0);

        // done held through reset release must not capture
        done_in = 1'b1; alu_in = 16'h0099;
        clear_n = 1'b0;
        tick(); tick();
        clear_n = 1'b1;
        tick(); tick();
        chk("t6_held_count", 32'(count), 32'd0);
        done_in = 1'b0;
        tick();
        done_in = 1'b1; alu_in = 16'h0055; cs_in = 3'd2;
        tick();
        done_in = 1'b0;
        chk("t6_rise_count", 32'(count), 32'd1);
        chk("t6_rise_data", 32'(res_data), 32'h0055);
        chk("t6_rise_tag", 32'(res_tag), 32'd2);
        tick();

        // Reset mid-stream with three entries queued
        capture(16'h0101, 3'd4);
        capture(16'h0202, 3'd4);
        chk("t7_count", 32'(count), 32'd3);
        clear_n = 1'b0;
        #1;
        chk("t7_valid", 32'(res_valid), 32'd0);
        chk("t7_data", 32'(res_data), 32'h0);
        chk("t7_tag", 32'(res_tag), 32'd0);
        chk("t7_count0", 32'(count), 32'd0);
        chk("t7_sum", 32'(sum), 32'h0);
        chk("t7_ovf", 32'(overflow), 32'd0);
        tick();
        clear_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
